// File: rtl/sm_symbol_mapper_if.sv
// sm_symbol_mapper_if: handshake bundle; master drives flush/bit_in/bit_valid/sym_ready, slave drives bit_ready, out_*, sym_valid, sym_count, busy
interface sm_symbol_mapper_if #(parameter int CNT_W = 16);
  logic flush, bit_in, bit_valid, bit_ready;
  logic [4:0] out_q;
  logic [2:0] out_m_dI1, out_m_dI2, out_m_dQ1, out_m_dQ2;
  logic sym_valid, sym_ready, busy;
  logic [CNT_W-1:0] sym_count;
  modport master (
    output flush, bit_in, bit_valid, sym_ready,
    input bit_ready, out_q, out_m_dI1, out_m_dI2, out_m_dQ1, out_m_dQ2, sym_valid, sym_count, busy
  );
  modport slave (
    input flush, bit_in, bit_valid, sym_ready,
    output bit_ready, out_q, out_m_dI1, out_m_dI2, out_m_dQ1, out_m_dQ2, sym_valid, sym_count, busy
  );
endinterface

// File: rtl/sm_symbol_mapper.sv
// sm_symbol_mapper: serial bits -> Gray 4-PAM spatial-modulation tuples via small FIFO; ports clk, rst, bus (slave: bits in, symbols out, sym_count, busy)
module sm_symbol_mapper #(
  parameter int Q_BITS = 4,
  parameter int M_BITS = 2,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  sm_symbol_mapper_if.slave bus
);
  localparam int S = Q_BITS + 4 * M_BITS;
  localparam int CW = $clog2(S);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [S-2:0] r_sr;
  logic [CW-1:0] r_bit_cnt;
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_count;
  logic [CNT_W-1:0] r_sym_count;
  logic [16:0] r_mem [FIFO_DEPTH];
  logic w_last, w_accept, w_push, w_pop;
  logic [S-1:0] w_word;
  logic [16:0] w_entry;
  function automatic logic [2:0] pam(input logic [1:0] b);
    return b == 2'b00 ? 3'b101 : b == 2'b01 ? 3'b111 : b == 2'b11 ? 3'b001 : 3'b011;
  endfunction
  assign w_last = r_bit_cnt == CW'(S - 1);
  assign bus.bit_ready = !rst && (!w_last || r_count < (AW+1)'(FIFO_DEPTH) || bus.sym_ready);
  assign w_accept = bus.bit_valid && bus.bit_ready;
  assign w_word = {r_sr, bus.bit_in};
  assign w_push = w_accept && w_last && !bus.flush;
  assign w_pop = r_count != '0 && bus.sym_ready;
  assign w_entry = {5'(w_word[S-1 -: Q_BITS]), pam(w_word[7:6]), pam(w_word[5:4]), pam(w_word[3:2]), pam(w_word[1:0])};
  assign {bus.out_q, bus.out_m_dI1, bus.out_m_dI2, bus.out_m_dQ1, bus.out_m_dQ2} = r_mem[r_rp];
  assign bus.sym_valid = r_count != '0;
  assign bus.sym_count = r_sym_count;
  assign bus.busy = r_bit_cnt != '0 || r_count != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr <= '0;
      r_bit_cnt <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
      r_sym_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (bus.flush) begin
        r_sr <= '0;
        r_bit_cnt <= '0;
      end else if (w_accept) begin
        r_sr <= w_word[S-2:0];
        r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;
      end
      if (w_push) begin
        r_mem[r_wp] <= w_entry;
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
        r_sym_count <= r_sym_count + 1'b1;
      end
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: tb/tb_sm_symbol_mapper.sv
// tb_sm_symbol_mapper: directed scoreboard bench for sm_symbol_mapper
module tb_sm_symbol_mapper;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  sm_symbol_mapper_if #(.CNT_W(16)) bus();
  sm_symbol_mapper_if #(.CNT_W(4)) bus4();
  sm_symbol_mapper dut (.clk(clk), .rst(rst), .bus(bus));
  sm_symbol_mapper #(.CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  assign bus4.flush = bus.flush;
  assign bus4.bit_in = bus.bit_in;
  assign bus4.bit_valid = bus.bit_valid;
  assign bus4.sym_ready = bus.sym_ready;
  int checks = 0;
  int failures = 0;
  int exp_count = 0;
  logic [16:0] sb[$];
  wire [16:0] head = {bus.out_q, bus.out_m_dI1, bus.out_m_dI2, bus.out_m_dQ1, bus.out_m_dQ2};
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [2:0] amp(input logic [1:0] b);
    case (b)
      2'b00: return 3'(-3);
      2'b01: return 3'(-1);
      2'b11: return 3'(1);
      default: return 3'(3);
    endcase
  endfunction
  function automatic logic [16:0] tuple(input logic [3:0] q, input logic [7:0] m);
    return {1'b0, q, amp(m[7:6]), amp(m[5:4]), amp(m[3:2]), amp(m[1:0])};
  endfunction
  always @(negedge clk) begin
    if (!rst && bus.sym_valid && bus.sym_ready) begin
      if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
      else check("sym_tuple", 32'(head), 32'(sb.pop_front()));
      exp_count++;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) step();
  endtask
  task automatic send_bit(input logic b);
    int n = 0;
    bus.bit_in = b;
    bus.bit_valid = 1;
    @(negedge clk);
    while (!bus.bit_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("ready_timeout", 32'(n), 32'd0);
    step();
    bus.bit_valid = 0;
  endtask
  task automatic send_word(input logic [11:0] w, input int nb, input bit gap);
    for (int i = 11; i > 11 - nb; i--) begin
      send_bit(w[i]);
      if (gap) step();
    end
  endtask
  task automatic send_sym(input logic [3:0] q, input logic [7:0] m, input bit gap);
    sb.push_back(tuple(q, m));
    send_word({q, m}, 12, gap);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.flush = 0;
    bus.bit_in = 0;
    bus.bit_valid = 0;
    bus.sym_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_bit_ready", bus.bit_ready, 0);
    check("rst_sym_valid", bus.sym_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_sym_count", bus.sym_count, 0);
    check("rst_head", head, 0);
    step();
    rst = 0;
    @(negedge clk);
    check("ready_after_rst", bus.bit_ready, 1);
    step();
    bus.sym_ready = 1;
    send_sym(4'h5, 8'b00_01_11_10, 0);
    @(negedge clk);
    check("single_valid", bus.sym_valid, 1);
    check("single_q", bus.out_q, 5);
    check("single_dI1", bus.out_m_dI1, 3'b101);
    check("single_dI2", bus.out_m_dI2, 3'b111);
    check("single_dQ1", bus.out_m_dQ1, 3'b001);
    check("single_dQ2", bus.out_m_dQ2, 3'b011);
    step();
    @(negedge clk);
    check("single_valid_drop", bus.sym_valid, 0);
    check("single_count", bus.sym_count, 1);
    check("single_busy", bus.busy, 0);
    step();
    bus.sym_ready = 0;
    send_sym(4'd1, 8'hAA, 0);
    send_sym(4'd2, 8'hAA, 0);
    sb.push_back(tuple(4'd3, 8'hAA));
    send_word({4'd3, 8'hAA}, 11, 0);
    bus.bit_in = 1'b0;
    bus.bit_valid = 1;
    @(negedge clk);
    check("bp_ready_low", bus.bit_ready, 0);
    check("bp_count_hold", bus.sym_count, 1);
    check("bp_busy", bus.busy, 1);
    check("bp_head_q", bus.out_q, 1);
    step();
    bus.sym_ready = 1;
    @(negedge clk);
    check("full_pushpop_ready", bus.bit_ready, 1);
    step();
    bus.bit_valid = 0;
    @(negedge clk);
    check("full_still_valid", bus.sym_valid, 1);
    check("full_head_q", bus.out_q, 2);
    idle(3);
    @(negedge clk);
    check("bp_drained", bus.sym_valid, 0);
    check("bp_count", bus.sym_count, 4);
    check("bp_model_count", bus.sym_count, 32'(exp_count));
    check("bp_sb_empty", 32'(sb.size()), 0);
    check("bp_busy_done", bus.busy, 0);
    step();
    send_word(12'hA5A, 7, 0);
    bus.flush = 1;
    @(negedge clk);
    check("flush_busy_partial", bus.busy, 1);
    check("flush_ready", bus.bit_ready, 1);
    step();
    bus.flush = 0;
    @(negedge clk);
    check("flush_busy_clear", bus.busy, 0);
    step();
    send_sym(4'hF, 8'hFF, 0);
    idle(2);
    @(negedge clk);
    check("flush_count", bus.sym_count, 5);
    check("flush_sb_empty", 32'(sb.size()), 0);
    check("flush_busy_done", bus.busy, 0);
    step();
    send_word(12'h3C3, 11, 0);
    bus.bit_in = 1;
    bus.bit_valid = 1;
    bus.flush = 1;
    step();
    bus.bit_valid = 0;
    bus.flush = 0;
    @(negedge clk);
    check("flush_last_no_push", bus.sym_valid, 0);
    check("flush_last_busy", bus.busy, 0);
    check("flush_last_count", bus.sym_count, 5);
    step();
    bus.sym_ready = 0;
    send_sym(4'd7, 8'h1B, 0);
    send_word(12'hFFF, 5, 0);
    @(negedge clk);
    check("pre_rst_busy", bus.busy, 1);
    check("pre_rst_valid", bus.sym_valid, 1);
    step();
    rst = 1;
    @(negedge clk);
    check("rst_mid_ready", bus.bit_ready, 0);
    step();
    rst = 0;
    sb.delete();
    exp_count = 0;
    @(negedge clk);
    check("rst_mid_valid", bus.sym_valid, 0);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_count", bus.sym_count, 0);
    check("rst_mid_count4", bus4.sym_count, 0);
    step();
    bus.sym_ready = 1;
    send_sym(4'd10, 8'h6C, 0);
    idle(2);
    @(negedge clk);
    check("post_rst_count", bus.sym_count, 1);
    check("post_rst_sb", 32'(sb.size()), 0);
    step();
    send_sym(4'd9, 8'h55, 1);
    send_sym(4'd6, 8'h55, 1);
    idle(2);
    @(negedge clk);
    check("gap_count", bus.sym_count, 3);
    check("gap_sb", 32'(sb.size()), 0);
    step();
    for (int k = 0; k < 13; k++) send_sym(4'(k), 8'(k * 37), 0);
    idle(2);
    @(negedge clk);
    check("wrap_count16", bus.sym_count, 16);
    check("wrap_count4_zero", bus4.sym_count, 0);
    check("wrap_model", 32'(exp_count), 16);
    step();
    send_sym(4'hE, 8'h99, 0);
    idle(2);
    @(negedge clk);
    check("wrap_count4_one", bus4.sym_count, 1);
    check("wrap_count17", bus.sym_count, 17);
    check("final_sb", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sm_symbol_mapper.md
Name: sm_symbol_mapper

Overview:
- Transmit-side mapper for the spatial-modulation link. It converts a serial bit stream into the symbol tuples that the receiver's distance/min-search chain recovers.
- Each symbol is one antenna-combination index q plus four Gray-coded 4-PAM amplitudes (dI1, dI2, dQ1, dQ2).
- Sits between the scrambled bit source and the antenna/IQ mapping stage.
- Symbol fields use the same encoding as the detector outputs (q 5 bits, m 3-bit signed), so loopback comparison is direct.

Parameters:
- Q_BITS, 4, bits selecting antenna combination (16 candidates).
- M_BITS, 2, bits per PAM component (fixed 4-PAM; only value 2 supported).
- FIFO_DEPTH, 2, output symbol buffer entries (power of 2, ≥2).
- CNT_W, 16, width of the symbol counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- flush  in  1  discard the partially assembled symbol (FIFO contents kept).
- bit_in  in  1  serial data bit, MSB of symbol first.
- bit_valid  in  1  bit_in valid.
- bit_ready  out  1  mapper accepts bit this cycle.
- out_q  out  5  antenna index, zero-extended from Q_BITS.
- out_m_dI1  out  3  signed PAM amplitude, component dI1.
- out_m_dI2  out  3  signed PAM amplitude, component dI2.
- out_m_dQ1  out  3  signed PAM amplitude, component dQ1.
- out_m_dQ2  out  3  signed PAM amplitude, component dQ2.
- sym_valid  out  1  FIFO head valid.
- sym_ready  in  1  downstream takes head.
- sym_count  out  CNT_W  symbols popped since reset, wraps modulo 2^CNT_W.
- busy  out  1  partial symbol pending or FIFO non-empty.

Behaviour:
- Symbol width S = Q_BITS + 4*M_BITS = 12 bits.
- Accept: a bit is taken on an edge where bit_valid && bit_ready.
  - The bit shifts into the assembly register: sr <= {sr[S-2:0], bit_in}.
  - bit_cnt increments from 0 to S-1.
- Field split of the completed word w[11:0]:
  - q = w[11:8]
  - dI1 = w[7:6], dI2 = w[5:4], dQ1 = w[3:2], dQ2 = w[1:0].
- Gray 4-PAM mapping: 00→-3, 01→-1, 11→+1, 10→+3. Outputs are 3-bit two's complement (-3 = 3'b101).
- Completion: on the edge that accepts bit S-1:
  - the mapped tuple is written into the FIFO;
  - bit_cnt returns to 0.
- Latency: with the FIFO empty, sym_valid rises in the cycle after the completing edge, holding that tuple.
- bit_ready = !rst && (bit_cnt != S-1 || fifo_count < FIFO_DEPTH || sym_ready).
  - This is combinational and allows a simultaneous push and pop when the FIFO is full.
- Output handshake:
  - The head is popped on an edge where sym_valid && sym_ready; sym_count then increments.
  - The out_* fields always show the FIFO head and hold stable while sym_valid && !sym_ready.
- FIFO behaviour:
  - Simultaneous push and pop: fifo_count is unchanged and order is preserved.
  - Push to a full FIFO is impossible by construction of bit_ready.
  - Pop when empty is ignored.
- flush:
  - When high, bit_cnt and sr clear at the edge and any bit accepted that same edge is discarded.
  - bit_ready still follows its formula during flush.
  - flush does not touch the FIFO, sym_valid or sym_count.
- flush on the completing edge: the symbol is discarded (flush wins, no push).
- busy = (bit_cnt != 0) || (fifo_count != 0).
- Reset, mid-operation included: at the edge, clear the partial symbol, FIFO, sym_count and bit_cnt.
- Reset values of outputs:
  - sym_valid = 0, sym_count = 0, busy = 0, bit_ready = 0 while rst is high.
  - out_q = 0 and all out_m_* = 0 while empty after reset. When the FIFO is empty, out_* show the last stored entry; their values are don't-care while sym_valid = 0.
- No internal pacing: one symbol per S accepted bits, no gaps required.

Test Plan:
- Single symbol, bits 0101_00_01_11_10, bit_valid always high, sym_ready high:
  - after the 12th edge, sym_valid = 1 for one cycle;
  - out_q = 5, dI1 = -3, dI2 = -1, dQ1 = +1, dQ2 = +3;
  - sym_count becomes 1.
- Backpressure, sym_ready = 0, stream 3 symbols (q = 1, 2, 3, all m bits 10):
  - the FIFO fills with q = 1, 2;
  - bit_ready drops at bit_cnt = 11 of the 3rd symbol;
  - raise sym_ready: q = 1, 2, 3 pop in order, all m = +3, sym_count = 3.
- Full FIFO with simultaneous push/pop: sym_ready = 1 in the cycle the 3rd symbol completes:
  - bit_ready = 1 and the push and pop happen on the same edge;
  - fifo_count stays at 2 and no symbol is lost.
- Flush: after 7 bits, pulse flush, then send 1111_11_11_11_11:
  - exactly one symbol, q = 15, all m = +1;
  - busy is high during the 7 bits and low after the pop.
- Reset mid-operation: rst for 1 cycle with a partial symbol pending and 1 FIFO entry:
  - sym_valid = 0, busy = 0, sym_count = 0 after the edge;
  - the next 12 bits produce the correct symbol.
- Gaps: bit_valid toggles 1/0 for 24 bits (two symbols q = 9 then 6, all m bits 01):
  - both symbols are output correctly with all m = -1;
  - sym_count wraps from 0xFFFF to 0 when preloaded by popping 2^16 symbols (long test).
